// File: rtl/rstatus_sched.sv
// rstatus_sched: encodes exception status words for $r30, queues them in order and drains them through the shared regfile write port.
// Optional macro RSTATUS_FORWARD_EN adds rs_fwd_valid/rs_fwd_data, a bypass of the newest queued entry.
module rstatus_sched #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   alu_ovf,
    input  logic                   alu_valid,
    input  logic [4:0]             opcode,
    input  logic [4:0]             aluopcode,
    input  logic                   md_exc,
    input  logic                   md_is_div,
    input  logic                   setx_valid,
    input  logic [26:0]            setx_target,
    input  logic                   flush,
    input  logic                   wb_busy,
    output logic                   rs_we,
    output logic [31:0]            rs_data,
    output logic                   wb_hold,
    output logic                   alu_stall,
    output logic                   md_stall,
    output logic [$clog2(DEPTH):0] pending
`ifdef RSTATUS_FORWARD_EN
    ,
    output logic                   rs_fwd_valid,
    output logic [31:0]            rs_fwd_data
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FORCE = 2'd2
    } state_e;

    state_e         state_q;
    logic [SW-1:0]  starve_q;
    logic [31:0]    mem_q [DEPTH];
    logic [AW-1:0]  head_q, head_d;
    logic [AW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;

    logic [2:0]     alu_code;
    logic           alu_ev;
    logic           full;
    logic           empty;
    logic           push;
    logic [31:0]    wdata;

    // ALU overflow decode; unrecognised opcode/aluopcode pairs produce no event
    always_comb begin
        alu_code = 3'd0;
        if (alu_valid && alu_ovf) begin
            if (opcode == 5'b00000 && aluopcode == 5'b00000) begin
                alu_code = 3'd1;
            end else if (opcode == 5'b00101) begin
                alu_code = 3'd2;
            end else if (opcode == 5'b00000 && aluopcode == 5'b00001) begin
                alu_code = 3'd3;
            end
        end
    end

    assign alu_ev = (alu_code != 3'd0);
    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == CW'(0));

    // Stalls: a full queue blocks everyone; otherwise the ALU/setx stage loses to multdiv
    assign md_stall  = md_exc && full;
    assign alu_stall = (alu_ev || setx_valid) && (full || md_exc);

    assign push = !flush && !full && (md_exc || alu_ev || setx_valid);

    always_comb begin
        wdata = {5'b0, setx_target};
        if (md_exc) begin
            wdata = md_is_div ? 32'd5 : 32'd4;
        end else if (alu_ev) begin
            wdata = {29'b0, alu_code};
        end
    end

    assign rs_we   = !empty && (!wb_busy || state_q == S_FORCE);
    assign rs_data = empty ? 32'd0 : mem_q[head_q];
    assign wb_hold = (state_q == S_FORCE);
    assign pending = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (rs_we) begin
                head_d = head_q + AW'(1);
            end
            if (push) begin
                tail_d = tail_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(rs_we);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push) begin
                mem_q[tail_q] <= wdata;
            end
        end
    end

    // Port arbitration FSM: counts denied cycles and forces a one-cycle slot at the limit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            starve_q <= '0;
        end else if (flush) begin
            state_q  <= S_IDLE;
            starve_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    starve_q <= '0;
                    if (push) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rs_we) begin
                        starve_q <= '0;
                        if (count_d == CW'(0)) begin
                            state_q <= S_IDLE;
                        end
                    end else if (wb_busy) begin
                        starve_q <= starve_q + SW'(1);
                        if (starve_q + SW'(1) == SW'(STARVE_LIMIT)) begin
                            state_q <= S_FORCE;
                        end
                    end
                end
                S_FORCE: begin
                    starve_q <= '0;
                    state_q  <= (count_d == CW'(0)) ? S_IDLE : S_WAIT;
                end
                default: begin
                    state_q  <= S_IDLE;
                    starve_q <= '0;
                end
            endcase
        end
    end

`ifdef RSTATUS_FORWARD_EN
    // Newest entry sits one slot behind the tail pointer
    assign rs_fwd_valid = !empty;
    assign rs_fwd_data  = empty ? 32'd0 : mem_q[tail_q - AW'(1)];
`endif

endmodule

// File: tb/tb_rstatus_sched.sv
// tb_rstatus_sched: scenario tasks plus an in-order scoreboard of expected $r30 writes for rstatus_sched.
module tb_rstatus_sched;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned STARVE = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        alu_ovf = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  opcode = 5'd0;
    logic [4:0]  aluopcode = 5'd0;
    logic        md_exc = 1'b0;
    logic        md_is_div = 1'b0;
    logic        setx_valid = 1'b0;
    logic [26:0] setx_target = 27'd0;
    logic        flush = 1'b0;
    logic        wb_busy = 1'b0;
    logic        rs_we;
    logic [31:0] rs_data;
    logic        wb_hold;
    logic        alu_stall;
    logic        md_stall;
    logic [2:0]  pending;
`ifdef RSTATUS_FORWARD_EN
    logic        rs_fwd_valid;
    logic [31:0] rs_fwd_data;
`endif

    int          checks = 0;
    int          failures = 0;
    logic [31:0] sb [$];
    logic [31:0] mon_exp;

    always #5 clock = ~clock;

    rstatus_sched #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .alu_ovf     (alu_ovf),
        .alu_valid   (alu_valid),
        .opcode      (opcode),
        .aluopcode   (aluopcode),
        .md_exc      (md_exc),
        .md_is_div   (md_is_div),
        .setx_valid  (setx_valid),
        .setx_target (setx_target),
        .flush       (flush),
        .wb_busy     (wb_busy),
        .rs_we       (rs_we),
        .rs_data     (rs_data),
        .wb_hold     (wb_hold),
        .alu_stall   (alu_stall),
        .md_stall    (md_stall),
        .pending     (pending)
`ifdef RSTATUS_FORWARD_EN
        ,
        .rs_fwd_valid(rs_fwd_valid),
        .rs_fwd_data (rs_fwd_data)
`endif
    );

    // Every $r30 write must match the oldest outstanding expectation
    always @(negedge clock) begin
        if (reset_n && rs_we) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_write: unexpected rs_data=%h, none expected", rs_data);
            end else begin
                mon_exp = sb.pop_front();
                if (rs_data !== mon_exp) begin
                    failures++;
                    $display("FAIL sb_write: rs_data=%h expected %h", rs_data, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        alu_ovf = 1'b0; alu_valid = 1'b0; opcode = 5'd0; aluopcode = 5'd0;
        md_exc = 1'b0; md_is_div = 1'b0; setx_valid = 1'b0; setx_target = 27'd0;
        flush = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (sb.size() == 0 && pending == 3'd0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({rs_we, wb_hold, alu_stall, md_stall, pending, rs_data} !== 40'd0) begin
            failures++;
            $display("FAIL reset_outputs: we=%b hold=%b as=%b ms=%b pend=%0d data=%h expected all 0",
                     rs_we, wb_hold, alu_stall, md_stall, pending, rs_data);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_basic();
        bit ok;
        wb_busy = 1'b0;
        alu_valid = 1'b1; alu_ovf = 1'b1; opcode = 5'b00000; aluopcode = 5'b00000;
        sb.push_back(32'd1);
        tick();
        clear_inputs();
        @(negedge clock);
        checks++;
        if (rs_we !== 1'b1 || pending !== 3'd1) begin
            failures++;
            $display("FAIL alu_first_write: we=%b pend=%0d expected we=1 pend=1", rs_we, pending);
        end
        tick();
        @(negedge clock);
        checks++;
        if (rs_we !== 1'b0 || pending !== 3'd0) begin
            failures++;
            $display("FAIL alu_after_pop: we=%b pend=%0d expected we=0 pend=0", rs_we, pending);
        end
        // Unrecognised op pair and unqualified overflow are ignored
        alu_valid = 1'b1; alu_ovf = 1'b1; opcode = 5'b00000; aluopcode = 5'b00010;
        tick();
        alu_valid = 1'b0; opcode = 5'b00101;
        tick();
        clear_inputs();
        @(negedge clock);
        checks++;
        if (pending !== 3'd0 || rs_we !== 1'b0) begin
            failures++;
            $display("FAIL alu_ignored: pend=%0d we=%b expected 0 0", pending, rs_we);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL alu_drain: queue not drained, sb=%0d expected 0", sb.size()); end
    endtask

    task automatic test_priority();
        bit ok;
        wb_busy = 1'b0;
        alu_valid = 1'b1; alu_ovf = 1'b1; opcode = 5'b00101; aluopcode = 5'd0;
        md_exc = 1'b1; md_is_div = 1'b1;
        @(negedge clock);
        checks++;
        if (alu_stall !== 1'b1 || md_stall !== 1'b0) begin
            failures++;
            $display("FAIL prio_stall: alu_stall=%b md_stall=%b expected 1 0", alu_stall, md_stall);
        end
        sb.push_back(32'd5);
        tick();
        md_exc = 1'b0; md_is_div = 1'b0;
        @(negedge clock);
        checks++;
        if (alu_stall !== 1'b0 || rs_we !== 1'b1) begin
            failures++;
            $display("FAIL prio_second: alu_stall=%b we=%b expected 0 1", alu_stall, rs_we);
        end
        sb.push_back(32'd2);
        tick();
        clear_inputs();
        md_exc = 1'b1; md_is_div = 1'b0;
        sb.push_back(32'd4);
        tick();
        clear_inputs();
        wait_drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL prio_drain: queue not drained, sb=%0d expected 0", sb.size()); end
    endtask

    task automatic test_full();
        bit ok;
        wb_busy = 1'b1;
        for (int i = 1; i <= int'(DEPTH); i++) begin
            setx_valid = 1'b1; setx_target = 27'(i);
            @(negedge clock);
            checks++;
            if (alu_stall !== 1'b0) begin
                failures++;
                $display("FAIL full_fill_%0d: alu_stall=%b expected 0", i, alu_stall);
            end
            sb.push_back(32'(i));
            tick();
        end
        setx_target = 27'd5; md_exc = 1'b1; md_is_div = 1'b0;
        @(negedge clock);
        checks++;
        if (pending !== 3'd4 || alu_stall !== 1'b1 || md_stall !== 1'b1) begin
            failures++;
            $display("FAIL full_stall: pend=%0d as=%b ms=%b expected 4 1 1", pending, alu_stall, md_stall);
        end
        tick();
        md_exc = 1'b0; wb_busy = 1'b0;
        @(negedge clock);
        checks++;
        if (rs_we !== 1'b1 || alu_stall !== 1'b1) begin
            failures++;
            $display("FAIL full_deq_stall: we=%b alu_stall=%b expected 1 1", rs_we, alu_stall);
        end
        tick();
        @(negedge clock);
        checks++;
        if (pending !== 3'd3 || alu_stall !== 1'b0 || rs_we !== 1'b1) begin
            failures++;
            $display("FAIL full_refill: pend=%0d as=%b we=%b expected 3 0 1", pending, alu_stall, rs_we);
        end
        sb.push_back(32'd5);
        tick();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (rs_we !== 1'b1) begin
                failures++;
                $display("FAIL full_consec_%0d: we=%b expected 1", i, rs_we);
            end
            tick();
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL full_drain: queue not drained, sb=%0d expected 0", sb.size()); end
    endtask

    task automatic test_starve();
        bit ok;
        wb_busy = 1'b1;
        setx_valid = 1'b1; setx_target = 27'h1AB;
        sb.push_back(32'h1AB);
        tick();
        clear_inputs();
        for (int k = 1; k <= int'(STARVE); k++) begin
            @(negedge clock);
            checks++;
            if (rs_we !== 1'b0 || wb_hold !== 1'b0) begin
                failures++;
                $display("FAIL starve_denied_%0d: we=%b hold=%b expected 0 0", k, rs_we, wb_hold);
            end
            tick();
        end
        @(negedge clock);
        checks++;
        if (wb_hold !== 1'b1 || rs_we !== 1'b1) begin
            failures++;
            $display("FAIL starve_force: hold=%b we=%b expected 1 1", wb_hold, rs_we);
        end
        tick();
        @(negedge clock);
        checks++;
        if (wb_hold !== 1'b0 || rs_we !== 1'b0 || pending !== 3'd0) begin
            failures++;
            $display("FAIL starve_after: hold=%b we=%b pend=%0d expected 0 0 0", wb_hold, rs_we, pending);
        end
        wb_busy = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL starve_drain: queue not drained, sb=%0d expected 0", sb.size()); end
    endtask

    task automatic test_flush_reset();
        bit any_we;
        wb_busy = 1'b1;
        setx_valid = 1'b1; setx_target = 27'h10;
        tick();
        setx_target = 27'h11;
        tick();
        setx_target = 27'h12; flush = 1'b1;
        @(negedge clock);
        checks++;
        if (pending !== 3'd2) begin
            failures++;
            $display("FAIL flush_before: pend=%0d expected 2", pending);
        end
        tick();
        clear_inputs();
        wb_busy = 1'b0;
        any_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (rs_we === 1'b1 || pending !== 3'd0) any_we = 1'b1;
            tick();
        end
        checks++;
        if (any_we) begin
            failures++;
            $display("FAIL flush_after: write or pending seen after flush, expected none");
        end
        // Async reset mid-drain
        wb_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            setx_valid = 1'b1; setx_target = 27'(32'h21 + i);
            sb.push_back(32'h21 + 32'(i));
            tick();
        end
        clear_inputs();
        wb_busy = 1'b0;
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (rs_we !== 1'b0 || pending !== 3'd0) begin
            failures++;
            $display("FAIL async_reset: we=%b pend=%0d expected 0 0", rs_we, pending);
        end
        sb.delete();
        @(posedge clock); #1;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        bit          ok;
        logic [31:0] exp_d;
        logic [2:0]  exp_p;
        wb_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            clear_inputs();
            if (i % 2 == 0) begin
                setx_valid = 1'b1; setx_target = 27'(32'h100 + i);
                exp_d = 32'h100 + 32'(i);
            end else begin
                alu_valid = 1'b1; alu_ovf = 1'b1; opcode = 5'b00000; aluopcode = 5'b00001;
                exp_d = 32'd3;
            end
            exp_p = (i == 0) ? 3'd0 : 3'd1;
            @(negedge clock);
            checks++;
            if (alu_stall !== 1'b0 || pending !== exp_p) begin
                failures++;
                $display("FAIL b2b_%0d: alu_stall=%b pend=%0d expected 0 %0d", i, alu_stall, pending, exp_p);
            end
            sb.push_back(exp_d);
            tick();
        end
        clear_inputs();
        wait_drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_drain: queue not drained, sb=%0d expected 0", sb.size()); end
    endtask

`ifdef RSTATUS_FORWARD_EN
    task automatic test_forward();
        bit ok;
        wb_busy = 1'b1;
        alu_valid = 1'b1; alu_ovf = 1'b1; opcode = 5'b00000; aluopcode = 5'b00001;
        sb.push_back(32'd3);
        tick();
        clear_inputs();
        setx_valid = 1'b1; setx_target = 27'h7;
        sb.push_back(32'd7);
        tick();
        clear_inputs();
        @(negedge clock);
        checks++;
        if (rs_fwd_valid !== 1'b1 || rs_fwd_data !== 32'd7 || pending !== 3'd2) begin
            failures++;
            $display("FAIL fwd_newest: v=%b d=%h pend=%0d expected 1 7 2", rs_fwd_valid, rs_fwd_data, pending);
        end
        wb_busy = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok || rs_fwd_valid !== 1'b0) begin
            failures++;
            $display("FAIL fwd_drain: ok=%b v=%b expected 1 0", ok, rs_fwd_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alu_basic();
        test_priority();
        test_full();
        test_starve();
        test_flush_reset();
        test_back_to_back();
`ifdef RSTATUS_FORWARD_EN
        test_forward();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rstatus_sched.md
Name: rstatus_sched

Overview:
Schedules writes of exception status to $r30 (rstatus) into the shared register-file write port. It encodes ALU overflow, mult/div exceptions and setx requests into 32-bit status words and queues them in order. It drains the queue through the single writeback port, which normal writeback also uses. It sits between the execute/multdiv stages and the regfile write mux, and back-pressures the pipeline when its queue is full.

Parameters:
DEPTH, 4, pending-entry queue depth; power of two, 2..16
STARVE_LIMIT, 8, consecutive cycles of port denial before forcing a writeback slot

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
alu_ovf  input  1  ALU overflow this cycle (qualified by alu_valid)
alu_valid  input  1  ALU stage holds a valid instruction
opcode  input  5  ALU-stage instruction opcode
aluopcode  input  5  ALU-stage ALU op field
md_exc  input  1  multdiv result ready with exception, 1-cycle pulse
md_is_div  input  1  1 = div, 0 = mult; valid with md_exc
setx_valid  input  1  setx instruction issuing
setx_target  input  27  setx immediate
flush  input  1  squash all queued, not-yet-written entries
wb_busy  input  1  normal writeback owns the port this cycle
rs_we  output  1  write $r30 this cycle
rs_data  output  32  value written to $r30
wb_hold  output  1  forces normal writeback to stall this cycle
alu_stall  output  1  ALU/setx source must hold
md_stall  output  1  multdiv must hold its result
pending  output  $clog2(DEPTH)+1  queued entry count

Behaviour:
- Reset (async, reset_n=0): queue empty; pending=0; rs_we=0; rs_data=0; wb_hold=0; starve counter=0; FSM=IDLE. Stall outputs follow their combinational equations.
- Encoding, zero-extended to 32 bits:
  - opcode 00000 with aluopcode 00000 and overflow -> 1
  - opcode 00101 (addi) with overflow -> 2
  - opcode 00000 with aluopcode 00001 and overflow -> 3
  - md_exc with md_is_div=0 -> 4; with md_is_div=1 -> 5
  - setx -> {5'b0, setx_target}
  - alu_ovf with any other opcode/aluopcode is ignored.
- Enqueue: at most one entry per cycle. Fixed priority: md_exc > ALU event > setx.
  - A losing valid source gets its stall asserted in the same cycle and must hold its request.
  - An ALU event and setx never coincide, since both come from one stage.
- Full (pending==DEPTH): alu_stall=1 and md_stall=1 whenever their sources are valid. This holds even if a dequeue occurs the same cycle. Nothing is enqueued.
- Dequeue: rs_we = !empty && (!wb_busy || FSM==FORCE); rs_data = head entry.
  - The head is popped on every cycle rs_we=1.
  - Earliest rs_we is the cycle after enqueue (enqueue at edge N gives rs_we in cycle N+1).
  - Order is strict FIFO.
- Simultaneous enqueue and dequeue with the queue not full: pending is unchanged and pointers advance. Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: queue empty. Go to WAIT on enqueue.
  - WAIT: non-empty. Starve counter increments each cycle wb_busy=1 and clears on any pop. When the counter reaches STARVE_LIMIT, go to FORCE. On the last pop, go to IDLE.
  - FORCE: wb_hold=1 for exactly 1 cycle, and rs_we=1 that cycle regardless of wb_busy. Counter clears. Next state is WAIT if entries remain, else IDLE.
- flush: next edge sets pending=0, the FSM to IDLE and the counter to 0. An enqueue in the same cycle as flush is dropped. An rs_we already asserted in the flush cycle still completes.
- wb_hold is asserted only in FORCE.

Optional Feature:
RSTATUS_FORWARD_EN.
- Defined: adds outputs rs_fwd_valid (1) and rs_fwd_data (32), giving the newest queued entry (tail-1) so readers of $r30 can bypass the regfile. rs_fwd_valid = !empty. Both outputs reset to 0.
- Undefined: the ports are absent and no tail-side read mux is built.

Test Plan:
- Reset, alu_valid=1, opcode=00000, aluopcode=00000, alu_ovf=1, wb_busy=0 -> next cycle rs_we=1, rs_data=1, then pending=0.
- addi overflow (opcode=00101) and md_exc div in the same cycle -> div entry (5) enqueued, alu_stall=1. Next cycle the addi entry (2) is enqueued. Writes appear in order 5, 2.
- Hold wb_busy=1 and enqueue DEPTH setx entries with targets 0x1..0x4 -> pending=4. A fifth request gets alu_stall=1. Release wb_busy -> writes 1, 2, 3, 4 on consecutive cycles.
- One entry queued with wb_busy held high -> after 8 denied cycles wb_hold=1 and rs_we=1 for one cycle, then the FSM returns to IDLE.
- Two entries queued, flush=1 -> pending=0 next cycle and no further rs_we. Assert reset_n=0 mid-drain -> rs_we drops immediately (async).
- With RSTATUS_FORWARD_EN: enqueue 3 then setx 0x7 -> rs_fwd_data=7 while both are pending.
